cache_line_writer: RTL and testbench
====================================

# cache_line_writer

Write-back serializer for the data cache: on eviction of a dirty line, it captures the whole line and its address in one cycle. It then writes the line to main memory one word per accepted transfer, using incrementing word-aligned addresses. It is the counterpart of the line-fill adapter: that block gathers memory words into a line, and this block scatters a line back out to memory. It sits between the cache controller (eviction side) and the memory write port.

## Interface
- WORD_SIZE, 32, data/address width in bits
- WORDS_PER_LINE, 8, words per cache line; power of two, ≥2
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  begin write-back; sampled only in IDLE
- line_addr_i  in  WORD_SIZE  any byte address inside the victim line
- line_i  in  WORD_SIZE*WORDS_PER_LINE  victim line, flattened; word k at bits [k*WORD_SIZE +: WORD_SIZE]
- mem_we  out  1  write request valid
- mem_addr  out  WORD_SIZE  byte address of current word
- mem_data  out  WORD_SIZE  current word
- mem_ready  in  1  memory accepts the current word this cycle
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Reset is asynchronous and active-low. One clock domain.
- States are IDLE, WRITE and DONE.
- **IDLE**
  - When start=1, the block latches line_i into an internal WORDS_PER_LINE×WORD_SIZE buffer.
  - It latches the base address as line_addr_i with the low log2(WORDS_PER_LINE)+2 bits cleared.
  - It clears the word counter and moves to WRITE.
  - When start=0, it stays in IDLE.
- **WRITE**
  - mem_we=1.
  - mem_addr = base + (counter << 2).
  - mem_data = buf[counter].
  - On mem_ready=1 with counter = WORDS_PER_LINE−1, the block moves to DONE; otherwise the counter increments.
  - When mem_ready=0, all outputs hold steady. No timeout applies.
- **DONE**
  - done=1 for exactly one cycle, then the block returns to IDLE.
- start is ignored in WRITE and DONE. No queuing or error is raised. The captured line is unaffected by changes on line_i after capture.
- While mem_we=0, mem_addr and mem_data are driven to 0.
- Address arithmetic is WORD_SIZE wide and unsigned. The counter is log2(WORDS_PER_LINE) bits. Addresses never cross the line boundary. The top line of the address space (base = all-ones aligned) must not wrap.
- Reset asserted mid-line:
  - The block returns immediately to IDLE with mem_we=0.
  - No done pulse is produced.
  - The partially written line is abandoned; the controller is responsible for restarting it.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, state=IDLE, counter=0. The buffer is not reset.
- start sampled at edge N → mem_we=1 with word 0 from cycle N+1.
- With mem_ready held 1:
  - Words 0..WORDS_PER_LINE−1 are presented on consecutive cycles.
  - done is asserted in the cycle after the last accept.
  - IDLE is re-entered one cycle later.
  - For the default parameters, start to done takes 9 cycles, and the next start is accepted 10 cycles after the previous one.
- A transfer completes only on a cycle with mem_we=1 and mem_ready=1. A mem_ready asserted outside WRITE is ignored.
- busy rises the cycle after start is accepted and falls the cycle after done.

## Structure
- Shared package cache_pkg:
  - WORD_SIZE and BYTE_BITS=2.
  - State enum typedef wb_state_t {IDLE, WRITE, DONE}.
  - Function line_base(addr) returning the aligned base.
- The fill adapter already uses line_base, and it must migrate to the package version.
- One sub-module, cache_line_addr_gen, is natural. It holds the word counter with clear/increment and produces base + (counter << BYTE_BITS) plus a last flag. The fill adapter can reuse it.

## Test plan
- **Single write-back, mem_ready=1.** Input: line_addr_i=0x0000_1234, word k = 0xA0+k, one start pulse. Expected: addresses 0x1220, 0x1224, …, 0x123C on 8 consecutive cycles with data 0xA0..0xA7, then a done pulse; 9 cycles from start to done.
- **Stalls.** Input: mem_ready low for 3 cycles on word 2 and low for 1 cycle on word 7. Expected: mem_addr and mem_data hold 0x1228/0xA2 while stalled; all 8 words are accepted exactly once, in order; done occurs 4 cycles later than in the unstalled case.
- **Capture isolation and start while busy.** Input: change line_i and pulse start while in WRITE and while in DONE. Expected: the original data is written, no second write-back occurs, and a single done pulse is produced.
- **Reset mid-operation.** Input: clr_n asserted low after word 3 is accepted, asynchronously between clock edges. Expected: mem_we=0 and busy=0 immediately; no done pulse; a new start afterwards writes a full 8-word line from word 0.
- **High-address line.** Input: line_addr_i=0xFFFF_FFF8. Expected: addresses 0xFFFF_FFE0..0xFFFF_FFFC with no wrap; done after the last word.
- **Parameter sweep.** Input: WORDS_PER_LINE=4 and 16, random stalls. Expected: the scoreboard matches the buffered line word-for-word; busy and done timing follow the rules above.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: word geometry, write-back FSM states and line alignment.
package cache_pkg;

  localparam int unsigned WORD_SIZE      = 32;
  localparam int unsigned BYTE_BITS      = 2;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wb_state_t;

  // Clears the byte-in-line offset bits; words must be a power of two.
  function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr,
                                                     input int unsigned words = WORDS_PER_LINE);
    logic [WORD_SIZE-1:0] span;
    span = WORD_SIZE'(words) << BYTE_BITS;
    return addr & ~(span - WORD_SIZE'(1));
  endfunction

endpackage

// File: rtl/cache_line_addr_gen.sv
// Word counter for a cache line with byte-address generation and a last-word flag.
module cache_line_addr_gen
  import cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = cache_pkg::WORD_SIZE,
  parameter int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              clear,
  input  logic                              inc,
  input  logic [WORD_SIZE-1:0]              base,
  output logic [$clog2(WORDS_PER_LINE)-1:0] count,
  output logic [WORD_SIZE-1:0]              addr,
  output logic                              last
);

  localparam int unsigned CntW = $clog2(WORDS_PER_LINE);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Base is line-aligned, so the offset never carries out of the line.
  assign count = count_q;
  assign addr  = base + (WORD_SIZE'(count_q) << BYTE_BITS);
  assign last  = (count_q == CntW'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_line_writer.sv
// Write-back serializer: captures a dirty line in one cycle and writes it to memory
// one word per accepted transfer at incrementing word addresses.
module cache_line_writer
  import cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = cache_pkg::WORD_SIZE,
  parameter int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                start,
  input  logic [WORD_SIZE-1:0]                line_addr_i,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_i,
  output logic                                mem_we,
  output logic [WORD_SIZE-1:0]                mem_addr,
  output logic [WORD_SIZE-1:0]                mem_data,
  input  logic                                mem_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned CntW = $clog2(WORDS_PER_LINE);

  wb_state_t            state_q;
  logic [WORD_SIZE-1:0] line_q [WORDS_PER_LINE];
  logic [WORD_SIZE-1:0] base_q;
  logic [WORD_SIZE-1:0] word_addr;
  logic [CntW-1:0]      count;
  logic                 last;
  logic                 capture;
  logic                 accept;

  assign capture = (state_q == IDLE) && start;
  assign accept  = (state_q == WRITE) && mem_ready;

  cache_line_addr_gen #(
    .WORD_SIZE      (WORD_SIZE),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_addr_gen (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (capture),
    .inc   (accept && !last),
    .base  (base_q),
    .count (count),
    .addr  (word_addr),
    .last  (last)
  );

  // Line buffer and base are only meaningful while mem_we is high, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      base_q <= line_base(line_addr_i, WORDS_PER_LINE);
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        line_q[k] <= line_i[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WRITE;
            mem_we  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ready && last) begin
            state_q <= DONE;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = mem_we ? word_addr : '0;
  assign mem_data = mem_we ? line_q[count] : '0;

endmodule

// File: tb/tb_cache_line_writer.sv
// Bench for cache_line_writer: three instances (4, 8, 16 words per line) share stimulus and
// are compared each cycle against a queue-based model of the expected memory writes.
module tb_cache_line_writer;

  localparam int unsigned NI = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        busy;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 clr_n;
  logic                 start;
  logic                 mem_ready;
  logic [31:0]          line_addr;
  logic [32*16-1:0]     line_all;
  logic [NI-1:0]        we_v, busy_v, done_v;
  logic [NI-1:0][31:0]  addr_v, data_v;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen1 = 0;
  exp_t exp_q [NI][$];
  logic [NI-1:0] done_f;
  vec_t tbl [10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = 4 << g;
    cache_line_writer #(
      .WORD_SIZE      (32),
      .WORDS_PER_LINE (W)
    ) u_dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .start       (start),
      .line_addr_i (line_addr),
      .line_i      (line_all[32*W-1:0]),
      .mem_we      (we_v[g]),
      .mem_addr    (addr_v[g]),
      .mem_data    (data_v[g]),
      .mem_ready   (mem_ready),
      .busy        (busy_v[g]),
      .done        (done_v[g])
    );
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      done_f[i] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic st, input logic rdy);
    for (int i = 0; i < NI; i++) begin
      int          w;
      logic [31:0] b;
      exp_t        e;
      w = 4 << i;
      if (done_f[i]) begin
        done_f[i] = 1'b0;
      end else if (exp_q[i].size() != 0) begin
        if (rdy) begin
          e = exp_q[i].pop_front();
          if (exp_q[i].size() == 0) done_f[i] = 1'b1;
        end
      end else if (st) begin
        b = line_addr - (line_addr % 32'(w * 4));
        for (int k = 0; k < w; k++) begin
          e.addr = b + 32'(4 * k);
          e.data = line_all[32*k +: 32];
          exp_q[i].push_back(e);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic        ew;
      logic [31:0] ea, ed;
      ew = (exp_q[i].size() != 0);
      ea = ew ? exp_q[i][0].addr : 32'h0;
      ed = ew ? exp_q[i][0].data : 32'h0;
      chk("mem_we", i, 32'(we_v[i]), 32'(ew));
      chk("mem_addr", i, addr_v[i], ea);
      chk("mem_data", i, data_v[i], ed);
      chk("done", i, 32'(done_v[i]), 32'(done_f[i]));
      chk("busy", i, 32'(busy_v[i]), 32'(ew | done_f[i]));
    end
    if (done_v[1]) done_seen1++;
  endtask

  task automatic tick(input logic st, input logic rdy);
    start     = st;
    mem_ready = rdy;
    model_step(st, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy_v != '0 && n < 60) begin
      tick(1'b0, 1'b1);
      n++;
    end
    for (int i = 0; i < NI; i++) chk("drain_busy", i, 32'(busy_v[i]), 32'h0);
  endtask

  task automatic load_line(input logic [31:0] addr, input logic [31:0] seed);
    line_addr = addr;
    for (int k = 0; k < 16; k++) line_all[32*k +: 32] = seed + 32'(k);
  endtask

  initial begin
    int k, cyc, stall2, stall7;
    logic rdy;

    clr_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    line_addr = '0; line_all = '0;
    model_clear();
    #2;
    check_all();
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check_all();

    // Single write-back, mem_ready held high
    load_line(32'h0000_1234, 32'hA0);
    for (int r = 0; r < 10; r++) begin
      tbl[r].st   = (r == 0);
      tbl[r].rdy  = 1'b1;
      tbl[r].we   = (r < 8);
      tbl[r].addr = (r < 8) ? 32'h1220 + 32'(4 * r) : 32'h0;
      tbl[r].data = (r < 8) ? 32'hA0 + 32'(r) : 32'h0;
      tbl[r].done = (r == 8);
      tbl[r].busy = (r < 9);
    end
    for (int r = 0; r < 10; r++) begin
      tick(tbl[r].st, tbl[r].rdy);
      chk("tbl_we", r, 32'(we_v[1]), 32'(tbl[r].we));
      chk("tbl_addr", r, addr_v[1], tbl[r].addr);
      chk("tbl_data", r, data_v[1], tbl[r].data);
      chk("tbl_done", r, 32'(done_v[1]), 32'(tbl[r].done));
      chk("tbl_busy", r, 32'(busy_v[1]), 32'(tbl[r].busy));
    end
    drain();

    // Stalls: 3 cycles on word 2, 1 cycle on word 7
    tick(1'b1, 1'b1);
    k = 0; cyc = 1; stall2 = 3; stall7 = 1;
    while (!done_v[1] && cyc < 40) begin
      rdy = 1'b1;
      if (k == 2 && stall2 > 0) begin rdy = 1'b0; stall2--; end
      else if (k == 7 && stall7 > 0) begin rdy = 1'b0; stall7--; end
      else if (we_v[1]) k++;
      tick(1'b0, rdy);
      cyc++;
      if (!rdy && k == 2) begin
        chk("stall_addr", 1, addr_v[1], 32'h1228);
        chk("stall_data", 1, data_v[1], 32'hA2);
      end
    end
    chk("stall_done_cycle", 1, 32'(cyc), 32'd13);
    drain();

    // Capture isolation and start while busy
    done_seen1 = 0;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    load_line(32'h0000_5678, 32'h5500);
    tick(1'b1, 1'b1);
    cyc = 0;
    while (!done_v[1] && cyc < 40) begin
      tick(1'b0, 1'b1);
      cyc++;
    end
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("iso_busy_after", 1, 32'(busy_v[1]), 32'h0);
    chk("iso_done_count", 1, 32'(done_seen1), 32'd1);
    drain();

    // Reset asynchronously after word 3 is accepted
    load_line(32'h0000_1234, 32'hA0);
    tick(1'b1, 1'b1);
    for (int r = 0; r < 4; r++) tick(1'b0, 1'b1);
    chk("pre_rst_addr", 1, addr_v[1], 32'h1230);
    #2 clr_n = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < NI; i++) begin
      chk("rst_we", i, 32'(we_v[i]), 32'h0);
      chk("rst_busy", i, 32'(busy_v[i]), 32'h0);
      chk("rst_done", i, 32'(done_v[i]), 32'h0);
    end
    @(negedge clk);
    clr_n = 1'b1;
    check_all();
    done_seen1 = 0;
    tick(1'b1, 1'b1);
    chk("restart_addr", 1, addr_v[1], 32'h1220);
    chk("restart_data", 1, data_v[1], 32'hA0);
    drain();
    chk("restart_done_count", 1, 32'(done_seen1), 32'd1);

    // Top line of the address space
    load_line(32'hFFFF_FFF8, 32'hC0);
    tick(1'b1, 1'b1);
    chk("hi_first_addr", 1, addr_v[1], 32'hFFFF_FFE0);
    for (int r = 0; r < 7; r++) tick(1'b0, 1'b1);
    chk("hi_last_addr", 1, addr_v[1], 32'hFFFF_FFFC);
    chk("hi_last_data", 1, data_v[1], 32'hC7);
    tick(1'b0, 1'b1);
    chk("hi_done", 1, 32'(done_v[1]), 32'h1);
    drain();

    // Randomized traffic across all three line sizes
    for (int c = 0; c < 600; c++) begin
      line_addr = $urandom;
      for (int w = 0; w < 16; w++) line_all[32*w +: 32] = $urandom;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
